// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback selection.
// It captures the memory-stage results and extracts sub-word load data.
// It then picks the ALU result, the load data or the link address as
// register-file write data, and counts the instructions that retire.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        hold the stage / load a bubble (flush wins)
//   in_*                memory-stage results for the incoming instruction
//   regWrite            register-file write enable (r0 writes suppressed)
//   write_reg           register-file write address (0 when the slot is empty)
//   write_data          register-file write data
//   wb_valid            stage holds a real instruction
//   retired_count       instructions that left the stage, wraps mod 2^CNT_W
module mem_wb_stage #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic             in_link,
    input  logic [4:0]       in_write_reg,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [31:0]      in_pc_plus8,
    input  logic [1:0]       in_load_size,
    input  logic             in_load_unsigned,
    output logic             regWrite,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Everything the stage carries from MEM into WB
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic             link;
        logic [REG_W-1:0] write_reg;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  mem_data;
        logic [XLEN-1:0]  pc_plus8;
        logic [1:0]       load_size;
        logic             load_unsigned;
    } stage_t;

    stage_t           stage_q;
    stage_t           stage_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             retire_c;
    logic [1:0]       offset_c;
    logic [1:0]       lane_c;
    logic             half_hi_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [XLEN-1:0]  load_data_c;

    // Stage capture: flush beats stall, stall beats a fresh load
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.valid = 1'b0;
        end else if (!stall) begin
            stage_d.valid         = in_valid;
            stage_d.reg_write     = in_reg_write;
            stage_d.mem_to_reg    = in_mem_to_reg;
            stage_d.link          = in_link;
            stage_d.write_reg     = in_write_reg;
            stage_d.alu_result    = in_alu_result;
            stage_d.mem_data      = in_mem_data;
            stage_d.pc_plus8      = in_pc_plus8;
            stage_d.load_size     = in_load_size;
            stage_d.load_unsigned = in_load_unsigned;
        end
    end

    // An instruction retires only when it actually moves out of the stage
    always_comb begin
        retire_c = stage_q.valid & ~stall & ~flush;
        count_d  = count_q + CNT_W'(retire_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    // Sub-word load extraction; lane_c is always in little-endian numbering
    always_comb begin
        offset_c  = stage_q.alu_result[1:0];
        lane_c    = BIG_ENDIAN ? 2'(2'd3 - offset_c) : offset_c;
        half_hi_c = BIG_ENDIAN ? ~offset_c[1] : offset_c[1];

        byte_c = stage_q.mem_data[7:0];
        case (lane_c)
            2'd0:    byte_c = stage_q.mem_data[7:0];
            2'd1:    byte_c = stage_q.mem_data[15:8];
            2'd2:    byte_c = stage_q.mem_data[23:16];
            default: byte_c = stage_q.mem_data[31:24];
        endcase

        half_c = half_hi_c ? stage_q.mem_data[31:16] : stage_q.mem_data[15:0];

        load_data_c = stage_q.mem_data;
        case (stage_q.load_size)
            SIZE_HALF: load_data_c = {{16{~stage_q.load_unsigned & half_c[15]}}, half_c};
            SIZE_BYTE: load_data_c = {{24{~stage_q.load_unsigned & byte_c[7]}}, byte_c};
            SIZE_WORD: load_data_c = stage_q.mem_data;
            default:   load_data_c = stage_q.mem_data;
        endcase
    end

    // Writeback select: link first, then load data, then ALU result
    always_comb begin
        if (stage_q.link) begin
            write_data = stage_q.pc_plus8;
        end else if (stage_q.mem_to_reg) begin
            write_data = load_data_c;
        end else begin
            write_data = stage_q.alu_result;
        end
    end

    assign regWrite      = stage_q.valid & stage_q.reg_write & (stage_q.write_reg != '0);
    assign write_reg     = stage_q.valid ? stage_q.write_reg : '0;
    assign wb_valid      = stage_q.valid;
    assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a default instance and a 4-bit-counter
// instance share one stimulus stream.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_link;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus8;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;

    logic        regWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_valid;
    logic [31:0] retired_count;

    logic        regWrite4;
    logic [4:0]  write_reg4;
    logic [31:0] write_data4;
    logic        wb_valid4;
    logic [3:0]  retired_count4;

    int n_vec;
    int n_err;
    int exp_cnt;
    bit model_valid;

    mem_wb_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
        .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    mem_wb_stage #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
        .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .regWrite(regWrite4), .write_reg(write_reg4), .write_data(write_data4),
        .wb_valid(wb_valid4), .retired_count(retired_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and update the retire-count model; outputs settle by #1
    task automatic tick();
        if (!rst_n) begin
            model_valid = 1'b0;
            exp_cnt     = 0;
        end else if (flush) begin
            model_valid = 1'b0;
        end else if (!stall) begin
            if (model_valid) exp_cnt++;
            model_valid = in_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input bit v, input bit rw, input bit m2r, input bit lnk,
                             input logic [4:0] wr, input logic [31:0] alu,
                             input logic [31:0] mem, input logic [31:0] pc8,
                             input logic [1:0] sz, input bit uns);
        stall            = 1'b0;
        flush            = 1'b0;
        in_valid         = v;
        in_reg_write     = rw;
        in_mem_to_reg    = m2r;
        in_link          = lnk;
        in_write_reg     = wr;
        in_alu_result    = alu;
        in_mem_data      = mem;
        in_pc_plus8      = pc8;
        in_load_size     = sz;
        in_load_unsigned = uns;
    endtask

    task automatic bubble();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic randomize_inputs();
        stall            = 1'($urandom);
        flush            = 1'($urandom);
        in_valid         = 1'($urandom);
        in_reg_write     = 1'($urandom);
        in_mem_to_reg    = 1'($urandom);
        in_link          = 1'($urandom);
        in_write_reg     = 5'($urandom);
        in_alu_result    = $urandom;
        in_mem_data      = $urandom;
        in_pc_plus8      = $urandom;
        in_load_size     = 2'($urandom);
        in_load_unsigned = 1'($urandom);
    endtask

    task automatic load_vec(input string tag, input logic [1:0] off, input logic [1:0] sz,
                            input bit uns, input logic [31:0] exp);
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, {30'h0, off}, 32'h80FF_7F01, 32'h0, sz, uns);
        tick();
        check(tag, write_data, exp);
        check({tag, "_cnt"}, retired_count, 32'(exp_cnt));
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        exp_cnt     = 0;
        model_valid = 1'b0;
        rst_n       = 1'b0;
        bubble();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            tick();
            check("rst_regwrite", 32'(regWrite), 32'h0);
            check("rst_wdata", write_data, 32'h0);
            check("rst_count", retired_count, 32'h0);
            check("rst_wbvalid", 32'(wb_valid), 32'h0);
        end
        bubble();
        rst_n = 1'b1;
        tick();
        check("post_rst_wreg", 32'(write_reg), 32'h0);

        // ALU writeback
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0);
        tick();
        check("alu_regwrite", 32'(regWrite), 32'h1);
        check("alu_wreg", 32'(write_reg), 32'd5);
        check("alu_wdata", write_data, 32'h1234_5678);
        check("alu_cnt0", retired_count, 32'd0);
        bubble();
        tick();
        check("alu_cnt1", retired_count, 32'd1);
        check("bubble_wreg", 32'(write_reg), 32'h0);
        check("bubble_regwrite", 32'(regWrite), 32'h0);

        // Sub-word loads from 0x80FF_7F01 (big-endian lanes)
        load_vec("lb_off0", 2'd0, 2'b10, 1'b0, 32'hFFFF_FF80);
        load_vec("lbu_off3", 2'd3, 2'b10, 1'b1, 32'h0000_0001);
        load_vec("lh_off2", 2'd2, 2'b01, 1'b0, 32'h0000_7F01);
        load_vec("lhu_off0", 2'd0, 2'b01, 1'b1, 32'h0000_80FF);
        load_vec("lb_off1", 2'd1, 2'b10, 1'b0, 32'hFFFF_FFFF);
        load_vec("lw_off3", 2'd3, 2'b00, 1'b0, 32'h80FF_7F01);
        load_vec("lsz11", 2'd1, 2'b11, 1'b0, 32'h80FF_7F01);

        // Link and r0 suppression
        set_instr(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 32'h0000_0002, 32'h80FF_7F01, 32'h0040_0010, 2'b10, 1'b0);
        tick();
        check("link_wdata", write_data, 32'h0040_0010);
        check("link_wreg", 32'(write_reg), 32'd31);
        check("link_regwrite", 32'(regWrite), 32'h1);
        in_write_reg = 5'd0;
        tick();
        check("r0_regwrite", 32'(regWrite), 32'h0);
        check("r0_wdata", write_data, 32'h0040_0010);
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'hCAFE_BABE, 32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        check("r0_counted", retired_count, 32'(exp_cnt));
        check("r0_counted_abs", retired_count, 32'd10);

        // Stall two cycles with new inputs on the bus
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h1111_1111, 32'h0, 32'h0, 2'b00, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_regwrite", 32'(regWrite), 32'h1);
            check("stall_wreg", 32'(write_reg), 32'd9);
            check("stall_wdata", write_data, 32'hCAFE_BABE);
            check("stall_cnt", retired_count, 32'd10);
        end

        // Flush together with stall: bubble in, nothing counted
        flush = 1'b1;
        tick();
        check("flush_wbvalid", 32'(wb_valid), 32'h0);
        check("flush_regwrite", 32'(regWrite), 32'h0);
        check("flush_wreg", 32'(write_reg), 32'h0);
        check("flush_cnt", retired_count, 32'd10);
        bubble();
        tick();
        check("post_flush_cnt", retired_count, 32'd10);

        // Asynchronous reset mid-operation
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h5555_AAAA, 32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        check("pre_arst_regwrite", 32'(regWrite), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_regwrite", 32'(regWrite), 32'h0);
        check("arst_wdata", write_data, 32'h0);
        check("arst_cnt", retired_count, 32'h0);
        check("arst_cnt4", 32'(retired_count4), 32'h0);
        bubble();
        tick();
        rst_n = 1'b1;
        model_valid = 1'b0;
        exp_cnt     = 0;

        // Wrap: 17 retirements on the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            set_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'(i + 1), 32'(i), 32'h0, 32'h0, 2'b00, 1'b0);
            tick();
        end
        check("wrap_cnt32_pre", retired_count, 32'd16);
        check("wrap_cnt4_pre", 32'(retired_count4), 32'd0);
        bubble();
        tick();
        check("wrap_cnt32", retired_count, 32'd17);
        check("wrap_cnt4", 32'(retired_count4), 32'd1);
        check("wrap_model", retired_count, 32'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback selection. Directly upstream of the register file write port; drives regWrite, write_reg and write_data.
- Captures memory-stage results, extracts and extends sub-word load data, and selects among ALU result, load data and link address.
- Supports stall and flush.
- Keeps a retired-instruction counter for bench and debug visibility.

Parameters:
- CNT_W, 32, width of retired_count; wraps modulo 2^CNT_W.
- BIG_ENDIAN, 1, byte-lane order for sub-word loads: 1 means offset 0 is bits [31:24]; 0 means offset 0 is bits [7:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold stage contents this cycle.
- flush  in  1  load a bubble this cycle; overrides stall.
- in_valid  in  1  upstream slot holds a real instruction.
- in_reg_write  in  1  instruction writes a GPR.
- in_mem_to_reg  in  1  result comes from load data.
- in_link  in  1  result is in_pc_plus8 (JAL/JALR/BGEZAL).
- in_write_reg  in  5  destination register number.
- in_alu_result  in  32  ALU result; also the load byte address.
- in_mem_data  in  32  raw word read from data memory.
- in_pc_plus8  in  32  link address.
- in_load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- in_load_unsigned  in  1  1 means zero-extend, 0 means sign-extend.
- regWrite  out  1  write enable to register file.
- write_reg  out  5  register file write address.
- write_data  out  32  register file write data.
- wb_valid  out  1  stage holds a valid instruction (for forwarding and hazard logic).
- retired_count  out  CNT_W  count of instructions retired.

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers, wb_valid, regWrite, write_reg, write_data and retired_count are 0. Outputs stay 0 until the first capture after rst_n rises.
- Capture at posedge clk, priority order:
  - flush: valid is cleared; other fields are don't-care.
  - else if stall: hold all fields.
  - else: load all in_* fields; valid is set from in_valid.
- Latency: one cycle from inputs to outputs. Outputs are combinational from the stage registers only, never from in_*.
- regWrite = valid & reg_write & (write_reg != 0). Writes to r0 are suppressed here, in addition to the register file's own guard.
- write_reg is the registered destination. It is 0 whenever valid is 0.
- write_data select, in priority order: link gives pc_plus8; else mem_to_reg gives extracted load; else alu_result.
- Load extraction uses registered alu_result[1:0] as the offset:
  - Word: the raw word unchanged; offset is ignored.
  - Half: offset[1] selects the halfword (BIG_ENDIAN=1: 0 gives [31:16], 1 gives [15:0]). offset[0] is ignored; misalignment is not trapped.
  - Byte: offset selects the lane.
  - Extension to 32 bits is per in_load_unsigned.
- wb_valid = valid.
- During stall with a valid slot, regWrite stays high and the same write repeats each cycle (idempotent).
- retired_count increments at posedge when valid & !stall & !flush, i.e. the instruction leaves the stage. It wraps from all-ones to 0.
- Simultaneous flush and stall: flush wins; the instruction in the stage is discarded and not counted.
- Reset mid-operation: the in-flight instruction is dropped, no write occurs, and the counter is zeroed.

Test Plan:
- Reset: rst_n=0 for 3 cycles with random inputs -> regWrite=0, write_data=0, retired_count=0 throughout.
- ALU writeback: valid, reg_write, dest 5, alu_result 0x1234_5678 -> the next cycle gives regWrite=1, write_reg=5, write_data=0x1234_5678; after the following edge, retired_count=1.
- Sub-word loads, mem_data 0x80FF_7F01:
  - signed byte, offset 0 -> 0xFFFF_FF80.
  - unsigned byte, offset 3 -> 0x0000_0001.
  - signed half, offset 2 -> 0x0000_7F01.
  - unsigned half, offset 0 -> 0x0000_80FF.
- Link and r0: link=1, pc_plus8=0x0040_0010, dest 31 -> write_data=0x0040_0010. Same instruction with dest 0 -> regWrite=0, counter still increments.
- Stall/flush: stall for 2 cycles -> outputs held and counter unchanged. flush together with stall -> wb_valid=0, regWrite=0 next cycle, counter unchanged.
- Wrap: CNT_W=4, retire 17 instructions -> retired_count=1.
